// File: rtl/mem_access_unit.sv
// Multi-cycle load/store controller between the CPU datapath and a handshaked data memory.
// Optional ISSUE timeout is enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        acc_err_o,
  output logic [31:0] ld_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        legal;
  logic [3:0]  be_new;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_limit;
  // Leaving ISSUE on the cycle the counter would reach TIMEOUT_CYC.
  assign cnt_limit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`endif

  // Access size/type decode and alignment check on the incoming request.
  always_comb begin
    legal  = 1'b0;
    be_new = 4'b0000;
    case (func3_i)
      3'b000, 3'b100: begin
        legal  = 1'b1;
        be_new = 4'b0001 << addr_i[1:0];
      end
      3'b001, 3'b101: begin
        legal  = ~addr_i[0];
        be_new = 4'b0011 << addr_i[1:0];
      end
      3'b010: begin
        legal  = (addr_i[1:0] == 2'b00);
        be_new = 4'b1111;
      end
      default: ;
    endcase
    if (is_store_i && func3_i[2]) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_data_d   = ld_data_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    acc_err_o   = 1'b0;
    mem_req_o   = 1'b0;
`ifdef MAU_TIMEOUT_EN
    cnt_d       = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          stall_o = 1'b1;
          if (legal) begin
            state_d     = StIssue;
            off_d       = addr_i[1:0];
            mem_we_d    = is_store_i;
            mem_be_d    = be_new;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wdata_d = st_data_i << {addr_i[1:0], 3'b000};
          end else begin
            state_d = StErr;
          end
        end
      end
      StIssue: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_d = StDone;
          if (!mem_we_q) begin
            ld_data_d = mem_rdata_i >> {off_q, 3'b000};
          end
`ifdef MAU_TIMEOUT_EN
        end else if (cnt_limit) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        acc_err_o = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_data_q   <= ld_data_d;
    end
  end

`ifdef MAU_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ld_data_o   = ld_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a behavioural access model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_store, mem_ack;
  logic [2:0]  func3;
  logic [31:0] addr, st_data, mem_rdata;
  logic        stall, done, acc_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] ld_data, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the persistent outputs
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_ld;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .is_store_i  (is_store),
    .func3_i     (func3),
    .addr_i      (addr),
    .st_data_i   (st_data),
    .stall_o     (stall),
    .done_o      (done),
    .acc_err_o   (acc_err),
    .ld_data_o   (ld_data),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f, input logic [31:0] a);
    int sz = size_of(f);
    if (sz == 0) return 0;
    if (st && sz != 4 && f[2]) return 0;
    return (a % sz) == 0;
  endfunction

  task automatic chk_mem(input string tag);
    chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, exp_we});
    chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, ".addr"}, mem_addr, exp_addr);
    chk({tag, ".wdata"}, mem_wdata, exp_wdata);
  endtask

  task automatic chk_ctl(input string tag, input bit s, input bit d, input bit e, input bit r);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".acc_err"}, {31'd0, acc_err}, {31'd0, e});
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, r});
  endtask

  // Full transaction: request in cycle 0, ack after 'waits' ISSUE cycles without ack.
  task automatic do_access(input string tag, input bit st, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int waits);
    int off = a % 4;
    @(negedge clk);
    req_valid = 1'b1; is_store = st; func3 = f; addr = a; st_data = sd; mem_ack = 1'b0;
    #1 chk_ctl({tag, ".c0"}, 1, 0, 0, 0);
    @(posedge clk); #1;
    if (!is_legal(st, f, a)) begin
      chk_ctl({tag, ".err"}, 0, 0, 1, 0);
      chk_mem({tag, ".err"});
      @(negedge clk); req_valid = 1'b0;
      @(posedge clk); #1;
      chk_ctl({tag, ".post"}, 0, 0, 0, 0);
      chk({tag, ".ld_hold"}, ld_data, exp_ld);
      return;
    end
    exp_we    = st;
    exp_be    = 4'((1 << size_of(f)) - 1) << off;
    exp_addr  = a - 32'(off);
    exp_wdata = sd << (8 * off);
    chk_ctl({tag, ".iss"}, 1, 0, 0, 1);
    chk_mem({tag, ".iss"});
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); mem_ack = 1'b0; mem_rdata = $urandom;
      @(posedge clk); #1;
      chk_ctl({tag, ".wait"}, 1, 0, 0, 1);
    end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    if (!st) exp_ld = rd >> (8 * off);
    chk_ctl({tag, ".done"}, 0, 1, 0, 0);
    chk({tag, ".ld_data"}, ld_data, exp_ld);
    chk_mem({tag, ".done"});
    @(negedge clk); mem_ack = 1'b0; req_valid = 1'b0; mem_rdata = $urandom;
    @(posedge clk); #1;
    chk_ctl({tag, ".idle"}, 0, 0, 0, 0);
    chk({tag, ".ld_hold"}, ld_data, exp_ld);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; func3 = 3'b000;
    addr = '0; st_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_ld = '0;
    #12;
    chk_ctl("reset", 0, 0, 0, 0);
    chk_mem("reset");
    chk("reset.ld_data", ld_data, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Load byte at 0x103 with two wait cycles.
    do_access("ldb", 0, 3'b000, 32'h103, 32'h0, 32'hAABBCCDD, 2);
    chk("ldb.be_lit", {28'd0, mem_be}, 32'h8);
    chk("ldb.addr_lit", mem_addr, 32'h100);
    chk("ldb.data_lit", ld_data, 32'h0000_00AA);
    // Store halfword at 0x202 with same-cycle ack.
    do_access("sth", 1, 3'b001, 32'h202, 32'h1234ABCD, 32'hDEADBEEF, 0);
    chk("sth.wdata_lit", mem_wdata, 32'hABCD_0000);
    chk("sth.be_lit", {28'd0, mem_be}, 32'hC);
    // Illegal: misaligned word load and store with func3 011.
    do_access("ldw_mis", 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    do_access("st011", 1, 3'b011, 32'h200, 32'h55, 32'h0, 0);
    do_access("sthu", 1, 3'b101, 32'h200, 32'h55, 32'h0, 0);

    // mem_ack while idle must be ignored.
    @(negedge clk); mem_ack = 1'b1;
    @(posedge clk); #1;
    chk_ctl("idle_ack", 0, 0, 0, 0);
    @(negedge clk); mem_ack = 1'b0;

    // Reset while in ISSUE drops everything immediately.
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h340;
    @(posedge clk); #1;
    chk_ctl("pre_rst", 1, 0, 0, 1);
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    #1;
    exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_ld = '0;
    chk_ctl("mid_rst", 0, 0, 0, 0);
    chk_mem("mid_rst");
    chk("mid_rst.ld", ld_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    do_access("after_rst", 0, 3'b101, 32'h3E, 32'h0, 32'h8765_4321, 1);

    // Request with no ack.
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b1; func3 = 3'b000; addr = 32'h77; st_data = 32'h5A;
    @(posedge clk);
`ifdef MAU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl("to.wait", 1, 0, 0, 1);
      @(posedge clk);
    end
    #1 chk_ctl("to.err", 0, 0, 1, 0);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    chk_ctl("to.idle", 0, 0, 0, 0);
`else
    for (int i = 0; i < 12; i++) begin
      #1 chk_ctl("noto.wait", 1, 0, 0, 1);
      @(posedge clk);
    end
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    #1 chk_ctl("noto.rst", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
`endif
    exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_ld = '0;
`ifdef MAU_TIMEOUT_EN
    exp_we = 1'b1; exp_be = 4'b1000; exp_addr = 32'h74; exp_wdata = 32'h5A00_0000;
    exp_ld = 32'h0000_8765;
`endif
    chk_mem("post_hang");
    chk("post_hang.ld", ld_data, exp_ld);

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] f;
      logic [31:0] a;
      bit st;
      st = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      do_access("rnd", st, f, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store controller between the CPU datapath and a handshaked data memory. It accepts one load or store per instruction and stalls the CPU until the memory acknowledges. It generates word-aligned addresses, byte enables and lane-shifted store data. For loads, it returns the addressed bytes right-justified in ld_data to the downstream load filter, which performs sign/zero extension.

## Interface
- TIMEOUT_CYC, 255: max cycles waiting for mem_ack (used only with MAU_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU has a load/store this instruction; held until done
- is_store  in  1  1 = store, 0 = load
- func3  in  3  access size/type (000 b, 001 h, 010 w, 100 bu, 101 hu)
- addr  in  32  byte address
- st_data  in  32  store data, right-justified
- stall  out  1  freeze PC/pipeline while high
- done  out  1  one-cycle pulse, access complete
- acc_err  out  1  one-cycle pulse, misaligned/illegal/timeout; no data returned
- ld_data  out  32  load word shifted right by 8*addr[1:0], zero-filled
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  st_data shifted left by 8*addr[1:0]
- mem_ack  in  1  memory accepted/completed request this cycle
- mem_rdata  in  32  read word, valid when mem_ack & ~mem_we

## Operation
- States: IDLE, ISSUE, DONE, ERR.
- IDLE: if req_valid, latch is_store, func3, addr, st_data. Check legality:
  - Loads: func3 ∈ {000, 001, 010, 100, 101}.
  - Stores: func3 ∈ {000, 001, 010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Legal → ISSUE. Illegal → ERR.
- ISSUE: mem_req=1 with registered mem_we/mem_be/mem_addr/mem_wdata stable. On mem_ack → DONE; for loads, register ld_data = mem_rdata >> (8*addr[1:0]).
- DONE: done=1 for one cycle, then → IDLE. req_valid is ignored in DONE (still the same instruction).
- ERR: acc_err=1 for one cycle, no memory access, then → IDLE.
- Byte enables:
  - b/bu: 4'b0001 << addr[1:0]
  - h/hu: 4'b0011 << addr[1:0]
  - w: 4'b1111
  - Loads drive the same mem_be.
- ld_data holds its value until the next load completes. Stores do not modify it.
- stall = (IDLE & req_valid) | ISSUE. It is combinational, low in DONE and ERR.

## Timing
- Reset (async): state IDLE; stall, done, acc_err, mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, ld_data = 0. Takes effect immediately, including mid-ISSUE: mem_req drops without waiting for ack.
- Cycle 0: IDLE with req_valid, stall=1.
- Cycle 1: ISSUE, mem_req=1.
- Cycle 1+k: mem_ack, where k ≥ 0 wait cycles.
- Cycle 2+k: DONE, done=1, stall=0, ld_data valid.
- Minimum latency is 3 cycles with same-cycle ack. Error path: cycle 1 ERR, acc_err=1.
- mem_ack outside ISSUE is ignored.
- mem_* outputs change only on the IDLE→ISSUE transition.

## Configuration
- MAU_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entering ISSUE and increments each ISSUE cycle without mem_ack.
  - When it reaches TIMEOUT_CYC, mem_req drops and the FSM → ERR (acc_err pulse).
  - An ack in the same cycle as the limit wins → DONE.
- Undefined: no counter; ISSUE waits indefinitely for mem_ack.

## Test plan
- Load b, addr 0x103, mem_rdata 0xAABBCCDD, ack after 2 waits → mem_be 1000, mem_addr 0x100, done in cycle 4, ld_data 0x000000AA, stall high cycles 0–3.
- Store h, addr 0x202, st_data 0x1234ABCD, same-cycle ack → mem_we=1, mem_be 1100, mem_wdata 0xABCD0000, done cycle 2.
- Load w, addr 0x101 → ERR at cycle 1, acc_err=1, mem_req never asserted; store func3 011 → same.
- Assert rst during ISSUE → mem_req, stall, done = 0 immediately; next req_valid restarts from IDLE.
- With MAU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack → mem_req high 4 cycles, then acc_err pulse; without the macro, mem_req stays high.
